// File: rtl/scan_mux.sv
// scan_mux: registered N:1 channel selector with manual and scan modes.
// In manual mode an external select picks the channel; in scan mode a dwell
// counter steps through every channel in turn and pulses wrap on return to 0.
module scan_mux #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SELW     = 2,
    parameter int DWELL    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHANNELS*WIDTH-1:0]   din,
    input  logic                        mode,
    input  logic [SELW-1:0]             sel_in,
    input  logic                        hold,
    output logic [WIDTH-1:0]            y,
    output logic                        y_valid,
    output logic [SELW-1:0]             cur_sel,
    output logic                        wrap
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SELW-1:0] LAST_CH   = SELW'(CHANNELS - 1);
    localparam logic [CW-1:0]   LAST_DWELL = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE,
        MANUAL,
        SCAN
    } state_t;

    state_t          state;
    logic [CW-1:0]   dwell_cnt;
    logic [SELW-1:0] sel_eff;

    // Explicit compare-based mux so a select outside the channel range can never
    // reach a nonexistent slice of din.
    function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] bus,
                                              input logic [SELW-1:0] s);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (s == SELW'(i)) begin
                r = bus[i*WIDTH +: WIDTH];
            end
        end
        return r;
    endfunction

    // Clamp out-of-range manual selects to the highest channel.
    always_comb begin
        sel_eff = sel_in;
        if (int'(sel_in) >= CHANNELS) begin
            sel_eff = LAST_CH;
        end
    end

    // Mode FSM, dwell counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dwell_cnt <= '0;
            cur_sel   <= '0;
            y         <= '0;
            y_valid   <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Outputs are left as reset; only the mode is latched here.
                    state     <= mode ? SCAN : MANUAL;
                    dwell_cnt <= '0;
                    wrap      <= 1'b0;
                end

                MANUAL: begin
                    dwell_cnt <= '0;
                    wrap      <= 1'b0;
                    if (!mode) begin
                        cur_sel <= sel_eff;
                        y       <= pick(din, sel_eff);
                        y_valid <= 1'b1;
                    end else begin
                        // Entering scan: keep the current channel, restart its dwell.
                        state   <= SCAN;
                        y       <= pick(din, cur_sel);
                        y_valid <= 1'b0;
                    end
                end

                SCAN: begin
                    if (mode) begin
                        y       <= pick(din, cur_sel);
                        y_valid <= 1'b1;
                        wrap    <= 1'b0;
                        if (!hold) begin
                            if (dwell_cnt == LAST_DWELL) begin
                                dwell_cnt <= '0;
                                if (cur_sel == LAST_CH) begin
                                    cur_sel <= '0;
                                    wrap    <= 1'b1;
                                end else begin
                                    cur_sel <= cur_sel + 1'b1;
                                end
                            end else begin
                                dwell_cnt <= dwell_cnt + 1'b1;
                            end
                        end
                    end else begin
                        // Leaving scan: manual rules take effect on this same edge.
                        state     <= MANUAL;
                        dwell_cnt <= '0;
                        wrap      <= 1'b0;
                        cur_sel   <= sel_eff;
                        y         <= pick(din, sel_eff);
                        y_valid   <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    dwell_cnt <= '0;
                    wrap      <= 1'b0;
                    y_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: directed vectors for scan_mux (4 channels, dwell 4) and a
// 3-channel, dwell-1 instance sharing clock, reset, select, hold and din.
module tb_scan_mux;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic        mode;
    logic        mode3;
    logic [1:0]  sel_in;
    logic        hold;
    logic [3:0]  y;
    logic        y_valid;
    logic [1:0]  cur_sel;
    logic        wrap;
    logic [3:0]  y3;
    logic        y_valid3;
    logic [1:0]  cur_sel3;
    logic        wrap3;

    int n_chk;
    int n_fail;

    scan_mux #(.WIDTH(4), .CHANNELS(4), .SELW(2), .DWELL(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .mode    (mode),
        .sel_in  (sel_in),
        .hold    (hold),
        .y       (y),
        .y_valid (y_valid),
        .cur_sel (cur_sel),
        .wrap    (wrap)
    );

    scan_mux #(.WIDTH(4), .CHANNELS(3), .SELW(2), .DWELL(1)) dut3 (
        .clk     (clk),
        .rst     (rst),
        .din     (din[11:0]),
        .mode    (mode3),
        .sel_in  (sel_in),
        .hold    (hold),
        .y       (y3),
        .y_valid (y_valid3),
        .cur_sel (cur_sel3),
        .wrap    (wrap3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic        hld;
        logic [15:0] d;
        logic [3:0]  ey;
        logic [1:0]  ecs;
        logic [3:0]  ey3;
        logic [1:0]  ecs3;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Scan sequence from reset release: edge 1 leaves IDLE, then each channel
    // is held for 4 edges, y shows the previous edge's channel.
    task automatic run_scan(input int e_lo, input int e_hi, input logic [15:0] dbus);
        int ch;
        int pch;
        for (int e = e_lo; e <= e_hi; e++) begin
            step();
            if (e == 1) begin
                chk("scan_e1_cur", 16'(cur_sel), 16'd0);
                chk("scan_e1_vld", 16'(y_valid), 16'd0);
                chk("scan_e1_y",   16'(y),       16'd0);
                chk("scan_e1_wrap", 16'(wrap),   16'd0);
            end else begin
                ch  = ((e - 1) / 4) % 4;
                pch = ((e - 2) / 4) % 4;
                chk("scan_cur",  16'(cur_sel), 16'(ch));
                chk("scan_y",    16'(y),       16'(dbus[pch*4 +: 4]));
                chk("scan_vld",  16'(y_valid), 16'd1);
                chk("scan_wrap", 16'(wrap),    ((e - 1) % 16 == 0) ? 16'd1 : 16'd0);
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;

        vecs[0] = '{2'd0, 1'b0, 16'hDCBA, 4'hA, 2'd0, 4'hA, 2'd0};
        vecs[1] = '{2'd1, 1'b0, 16'hDCBA, 4'hB, 2'd1, 4'hB, 2'd1};
        vecs[2] = '{2'd3, 1'b0, 16'hDCBA, 4'hD, 2'd3, 4'hC, 2'd2};
        vecs[3] = '{2'd2, 1'b0, 16'h1234, 4'h2, 2'd2, 4'h2, 2'd2};
        vecs[4] = '{2'd0, 1'b0, 16'h1234, 4'h4, 2'd0, 4'h4, 2'd0};
        vecs[5] = '{2'd3, 1'b1, 16'hF5E0, 4'hF, 2'd3, 4'h5, 2'd2};

        // Reset, then manual start-up.
        rst    = 1'b1;
        mode   = 1'b0;
        mode3  = 1'b0;
        sel_in = 2'd2;
        hold   = 1'b0;
        din    = 16'hDCBA;
        step();
        chk("rst_y",    16'(y),       16'd0);
        chk("rst_vld",  16'(y_valid), 16'd0);
        chk("rst_cur",  16'(cur_sel), 16'd0);
        chk("rst_wrap", 16'(wrap),    16'd0);
        rst = 1'b0;
        step();
        chk("idle_y",   16'(y),       16'd0);
        chk("idle_vld", 16'(y_valid), 16'd0);
        step();
        chk("man0_y",   16'(y),        16'hC);
        chk("man0_cur", 16'(cur_sel),  16'd2);
        chk("man0_vld", 16'(y_valid),  16'd1);
        chk("man0_y3",  16'(y3),       16'hC);

        // Manual-mode table, including clamp on the 3-channel instance.
        for (int i = 0; i < 6; i++) begin
            sel_in = vecs[i].sel;
            hold   = vecs[i].hld;
            din    = vecs[i].d;
            step();
            chk("tbl_y",     16'(y),        16'(vecs[i].ey));
            chk("tbl_cur",   16'(cur_sel),  16'(vecs[i].ecs));
            chk("tbl_vld",   16'(y_valid),  16'd1);
            chk("tbl_wrap",  16'(wrap),     16'd0);
            chk("tbl_y3",    16'(y3),       16'(vecs[i].ey3));
            chk("tbl_cur3",  16'(cur_sel3), 16'(vecs[i].ecs3));
            chk("tbl_vld3",  16'(y_valid3), 16'd1);
            chk("tbl_wrap3", 16'(wrap3),    16'd0);
        end

        // Scan from reset over two full wraps.
        hold = 1'b0;
        din  = 16'hDCBA;
        mode = 1'b1;
        rst  = 1'b1;
        step();
        chk("rst2_cur", 16'(cur_sel), 16'd0);
        rst = 1'b0;
        run_scan(1, 38, 16'hDCBA);

        // Hold on channel 1 with one dwell cycle already spent.
        hold = 1'b1;
        for (int h = 1; h <= 6; h++) begin
            step();
            chk("hold_cur",  16'(cur_sel), 16'd1);
            chk("hold_wrap", 16'(wrap),    16'd0);
            chk("hold_y",    16'(y),       (h <= 3) ? 16'hB : 16'h5);
            if (h == 3) din = 16'hDC5A;
        end
        hold = 1'b0;
        step();
        chk("rel1_cur", 16'(cur_sel), 16'd1);
        step();
        chk("rel2_cur", 16'(cur_sel), 16'd1);
        step();
        chk("rel3_cur", 16'(cur_sel), 16'd2);
        chk("rel3_y",   16'(y),       16'h5);
        step();
        chk("rel4_cur", 16'(cur_sel), 16'd2);
        chk("rel4_y",   16'(y),       16'hC);

        // Scan -> manual mid-dwell, then back to scan.
        mode   = 1'b0;
        sel_in = 2'd0;
        step();
        chk("s2m_y",    16'(y),       16'hA);
        chk("s2m_cur",  16'(cur_sel), 16'd0);
        chk("s2m_vld",  16'(y_valid), 16'd0);
        chk("s2m_wrap", 16'(wrap),    16'd0);
        step();
        chk("s2m1_vld", 16'(y_valid), 16'd1);
        chk("s2m1_y",   16'(y),       16'hA);
        mode = 1'b1;
        step();
        chk("m2s_cur", 16'(cur_sel), 16'd0);
        chk("m2s_vld", 16'(y_valid), 16'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("m2s_dwell_cur", 16'(cur_sel), 16'd0);
            chk("m2s_dwell_vld", 16'(y_valid), 16'd1);
            chk("m2s_dwell_y",   16'(y),       16'hA);
        end
        step();
        chk("m2s_step_cur",  16'(cur_sel), 16'd1);
        chk("m2s_step_wrap", 16'(wrap),    16'd0);
        step();
        chk("m2s_step_y",   16'(y),       16'h5);
        chk("m2s_step_vld", 16'(y_valid), 16'd1);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_y",    16'(y),       16'd0);
        chk("arst_vld",  16'(y_valid), 16'd0);
        chk("arst_cur",  16'(cur_sel), 16'd0);
        chk("arst_wrap", 16'(wrap),    16'd0);
        rst = 1'b0;
        run_scan(1, 10, 16'hDC5A);

        // Three channels, dwell 1: step every edge, wrap 2 -> 0.
        mode3 = 1'b1;
        step();
        chk("c3_cur0", 16'(cur_sel3), 16'd0);
        chk("c3_vld0", 16'(y_valid3), 16'd0);
        chk("c3_wr0",  16'(wrap3),    16'd0);
        step();
        chk("c3_cur1", 16'(cur_sel3), 16'd1);
        chk("c3_wr1",  16'(wrap3),    16'd0);
        chk("c3_y1",   16'(y3),       16'hA);
        chk("c3_vld1", 16'(y_valid3), 16'd1);
        step();
        chk("c3_cur2", 16'(cur_sel3), 16'd2);
        chk("c3_wr2",  16'(wrap3),    16'd0);
        chk("c3_y2",   16'(y3),       16'h5);
        step();
        chk("c3_cur3", 16'(cur_sel3), 16'd0);
        chk("c3_wr3",  16'(wrap3),    16'd1);
        chk("c3_y3",   16'(y3),       16'hC);
        step();
        chk("c3_cur4", 16'(cur_sel3), 16'd1);
        chk("c3_wr4",  16'(wrap3),    16'd0);
        chk("c3_y4",   16'(y3),       16'hA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
